// File: rtl/ref_conditioner_if.sv
// Reference-conditioner signal bundle: raw pin in, gated clean reference and status out.
interface ref_conditioner_if #(
  parameter int PERIOD_WIDTH = 16
);
  logic                    ref_raw_i;
  logic                    ref_clk_o;
  logic                    ref_edge_o;
  logic [PERIOD_WIDTH-1:0] period_o;
  logic                    ref_valid_o;
  logic                    ref_lost_o;

  modport master (
    output ref_raw_i,
    input  ref_clk_o, ref_edge_o, period_o, ref_valid_o, ref_lost_o
  );

  modport slave (
    input  ref_raw_i,
    output ref_clk_o, ref_edge_o, period_o, ref_valid_o, ref_lost_o
  );
endinterface

// File: rtl/ref_conditioner.sv
// Synchronises, deglitches and period-qualifies the external reference pin so that only
// a stable reference is passed on to the ADPLL; status reports valid/lost and the period.
module ref_conditioner #(
  parameter int PERIOD_WIDTH = 16,
  parameter int FILTER_LEN   = 3,
  parameter int MIN_PERIOD   = 8,
  parameter int TOL          = 2,
  parameter int LOCK_COUNT   = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic               fpga_clk_i,
  input  logic               reset_n_i,
  ref_conditioner_if.slave   bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef logic [PERIOD_WIDTH-1:0] period_t;
  typedef enum logic [1:0] {ST_LOST, ST_ACQUIRE, ST_VALID} state_t;

  localparam period_t                 CNT_MAX   = '1;
  localparam period_t                 MIN_P     = period_t'(MIN_PERIOD);
  localparam period_t                 TIMEOUT_P = period_t'(TIMEOUT);
  localparam logic [PERIOD_WIDTH:0]   TOL_P     = (PERIOD_WIDTH + 1)'(TOL);
  localparam logic [MW-1:0]           LOCK_M    = MW'(LOCK_COUNT);
  localparam logic [3:0]              FILT_N    = 4'(FILTER_LEN);

  logic                     sync1_q, sync2_q;
  logic                     filt_q, filt_d, filt_prev_q;
  logic [3:0]               run_q, run_d;
  logic                     edge_q, edge_d;
  period_t                  cnt_q, cnt_d, cnt_inc;
  period_t                  period_q, period_d;
  period_t                  pprev_q, pprev_d;
  logic                     pprev_ok_q, pprev_ok_d;
  logic [MW-1:0]            match_q, match_d;
  state_t                   state_q, state_d;
  logic                     ref_clk_q, gate_d;
  logic signed [PERIOD_WIDTH:0] diff;
  logic [PERIOD_WIDTH:0]    mag;
  logic                     glitch, tol_ok, timeout;

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q + 4'd1 == FILT_N) filt_d = ~filt_q;
      else                        run_d  = run_q + 4'd1;
    end
  end

  // The measured period is the cnt value this edge-cycle would load, so edges P apart read P.
  assign edge_d  = filt_q & ~filt_prev_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + period_t'(1);
  assign cnt_d   = edge_q ? period_t'(1) : cnt_inc;

  assign diff    = $signed({1'b0, cnt_inc}) - $signed({1'b0, pprev_q});
  assign mag     = diff[PERIOD_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign glitch  = cnt_inc < MIN_P;
  assign tol_ok  = pprev_ok_q && (mag <= TOL_P);
  assign timeout = !edge_q && (cnt_inc == TIMEOUT_P);

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    pprev_d    = pprev_q;
    pprev_ok_d = pprev_ok_q;
    period_d   = period_q;
    if (edge_d) begin
      unique case (state_q)
        ST_LOST: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          period_d = cnt_inc;
          if (glitch) begin
            match_d = '0;
          end else begin
            pprev_d    = cnt_inc;
            pprev_ok_d = 1'b1;
            if (tol_ok) begin
              match_d = match_q + MW'(1);
              if (match_q + MW'(1) == LOCK_M) state_d = ST_VALID;
            end else begin
              match_d = '0;
            end
          end
        end
        ST_VALID: begin
          period_d = cnt_inc;
          if (glitch || !tol_ok) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
            if (!glitch) begin
              pprev_d    = cnt_inc;
              pprev_ok_d = 1'b1;
            end
          end
        end
        default: state_d = ST_LOST;
      endcase
    end else if (timeout) begin
      state_d    = ST_LOST;
      match_d    = '0;
      pprev_ok_d = 1'b0;
    end
  end

  // Gate opens in the locking edge cycle and closes the cycle VALID is left.
  assign gate_d = (state_d == ST_VALID);

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      run_q       <= '0;
      edge_q      <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      pprev_q     <= '0;
      pprev_ok_q  <= 1'b0;
      match_q     <= '0;
      state_q     <= ST_LOST;
      ref_clk_q   <= 1'b0;
    end else begin
      sync1_q     <= bus.ref_raw_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      run_q       <= run_d;
      edge_q      <= edge_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pprev_q     <= pprev_d;
      pprev_ok_q  <= pprev_ok_d;
      match_q     <= match_d;
      state_q     <= state_d;
      ref_clk_q   <= filt_q & gate_d;
    end
  end

  assign bus.ref_clk_o   = ref_clk_q;
  assign bus.ref_edge_o  = edge_q;
  assign bus.period_o    = period_q;
  assign bus.ref_valid_o = (state_q == ST_VALID);
  assign bus.ref_lost_o  = (state_q == ST_LOST);

endmodule

// File: tb/tb_ref_conditioner.sv
// Directed bench for ref_conditioner: reset, lock latency, glitch rejection, tolerance, timeout.
module tb_ref_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   edge_cnt = 0;
  int   last_edge_cyc = 0;
  int   clk_hi = 0;

  ref_conditioner_if #(.PERIOD_WIDTH(16)) bus ();

  ref_conditioner dut (
    .fpga_clk_i (clk),
    .reset_n_i  (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ref_edge_o === 1'b1) begin
      edge_cnt      = edge_cnt + 1;
      last_edge_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One reference period: hi high, lo low, then an optional ghi-cycle pulse and glo low.
  task automatic wave(input int hi, input int lo, input int ghi = 0, input int glo = 0);
    int e0;
    e0 = edge_cnt;
    clk_hi = 0;
    bus.ref_raw_i = 1'b1;
    repeat (hi) begin tick(); if (bus.ref_clk_o) clk_hi++; end
    bus.ref_raw_i = 1'b0;
    repeat (lo) begin tick(); if (bus.ref_clk_o) clk_hi++; end
    bus.ref_raw_i = 1'b1;
    repeat (ghi) begin tick(); if (bus.ref_clk_o) clk_hi++; end
    bus.ref_raw_i = 1'b0;
    repeat (glo) begin tick(); if (bus.ref_clk_o) clk_hi++; end
    $display("wave %0d/%0d+%0d/%0d: edges=%0d period=%0d valid=%0d lost=%0d clk_hi=%0d",
             hi, lo, ghi, glo, edge_cnt - e0, bus.period_o, bus.ref_valid_o,
             bus.ref_lost_o, clk_hi);
  endtask

  // Acquire from LOST with a 26/26 square wave and check edge latency and lock point.
  task automatic lock_seq(input string tag);
    int e0;
    e0 = edge_cnt;
    bus.ref_raw_i = 1'b1;
    repeat (5) tick();
    chk({tag, "_edge_early"}, 32'(bus.ref_edge_o), 32'd0);
    tick();
    chk({tag, "_edge_latency"}, 32'(bus.ref_edge_o), 32'd1);
    chk({tag, "_lost_e1"}, 32'(bus.ref_lost_o), 32'd0);
    chk({tag, "_period_e1"}, 32'(bus.period_o), 32'd0);
    repeat (20) tick();
    bus.ref_raw_i = 1'b0;
    repeat (26) tick();
    wave(26, 26);
    chk({tag, "_period_e2"}, 32'(bus.period_o), 32'd52);
    repeat (3) wave(26, 26);
    chk({tag, "_valid_e5"}, 32'(bus.ref_valid_o), 32'd0);
    bus.ref_raw_i = 1'b1;
    repeat (5) tick();
    chk({tag, "_valid_pre_e6"}, 32'(bus.ref_valid_o), 32'd0);
    tick();
    chk({tag, "_edge_e6"}, 32'(bus.ref_edge_o), 32'd1);
    chk({tag, "_valid_e6"}, 32'(bus.ref_valid_o), 32'd1);
    chk({tag, "_clk_e6"}, 32'(bus.ref_clk_o), 32'd1);
    repeat (20) tick();
    bus.ref_raw_i = 1'b0;
    repeat (26) tick();
    chk({tag, "_edge_total"}, 32'(edge_cnt - e0), 32'd6);
    $display("lock_seq %s: edges=%0d period=%0d valid=%0d", tag, edge_cnt - e0,
             bus.period_o, bus.ref_valid_o);
  endtask

  initial begin
    int e0;
    bus.ref_raw_i = 1'b0;

    // Reset held with the pin toggling.
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.ref_raw_i = ~bus.ref_raw_i;
    end
    chk("rst_lost", 32'(bus.ref_lost_o), 32'd1);
    chk("rst_clk", 32'(bus.ref_clk_o), 32'd0);
    chk("rst_edge", 32'(bus.ref_edge_o), 32'd0);
    chk("rst_valid", 32'(bus.ref_valid_o), 32'd0);
    chk("rst_period", 32'(bus.period_o), 32'd0);
    bus.ref_raw_i = 1'b0;
    rst_n = 1'b1;
    e0 = edge_cnt;
    repeat (2000) tick();
    chk("idle_edges", 32'(edge_cnt - e0), 32'd0);
    chk("idle_lost", 32'(bus.ref_lost_o), 32'd1);
    chk("idle_valid", 32'(bus.ref_valid_o), 32'd0);
    chk("idle_period", 32'(bus.period_o), 32'd0);
    $display("idle 2000 cycles: edges=%0d lost=%0d", edge_cnt - e0, bus.ref_lost_o);

    // 26/26 square wave lock, then gated clock follows at 26 high cycles.
    lock_seq("sq");
    wave(26, 26);
    chk("sq_clk_high", 32'(clk_hi), 32'd26);
    chk("sq_valid", 32'(bus.ref_valid_o), 32'd1);

    // Short glitches in the low phase are rejected.
    e0 = edge_cnt;
    wave(26, 10, 2, 14);
    wave(26, 10, 2, 14);
    chk("gl_edges", 32'(edge_cnt - e0), 32'd2);
    chk("gl_period", 32'(bus.period_o), 32'd52);
    chk("gl_valid", 32'(bus.ref_valid_o), 32'd1);
    chk("gl_clk_high", 32'(clk_hi), 32'd26);

    // Alternating 51/53 stays in tolerance; edges measure the preceding wave.
    wave(26, 25);
    wave(26, 27);
    wave(26, 25);
    wave(26, 27);
    chk("alt_valid", 32'(bus.ref_valid_o), 32'd1);
    chk("alt_period", 32'(bus.period_o), 32'd51);
    wave(30, 30);
    chk("step_pre_valid", 32'(bus.ref_valid_o), 32'd1);
    chk("step_pre_period", 32'(bus.period_o), 32'd53);
    bus.ref_raw_i = 1'b1;
    repeat (5) tick();
    chk("step_valid_before", 32'(bus.ref_valid_o), 32'd1);
    tick();
    chk("step_edge", 32'(bus.ref_edge_o), 32'd1);
    chk("step_valid_drop", 32'(bus.ref_valid_o), 32'd0);
    chk("step_clk_drop", 32'(bus.ref_clk_o), 32'd0);
    chk("step_period", 32'(bus.period_o), 32'd60);
    repeat (24) tick();
    bus.ref_raw_i = 1'b0;
    repeat (30) tick();
    repeat (3) wave(30, 30);
    chk("step_valid_3", 32'(bus.ref_valid_o), 32'd0);
    wave(30, 30);
    chk("step_relock", 32'(bus.ref_valid_o), 32'd1);
    chk("step_relock_period", 32'(bus.period_o), 32'd60);

    // Return to 52, then stop the input and time out.
    repeat (6) wave(26, 26);
    chk("back52_valid", 32'(bus.ref_valid_o), 32'd1);
    chk("back52_period", 32'(bus.period_o), 32'd52);
    while (cyc < last_edge_cyc + 1023) tick();
    chk("to_lost_pre", 32'(bus.ref_lost_o), 32'd0);
    chk("to_valid_pre", 32'(bus.ref_valid_o), 32'd1);
    tick();
    chk("to_lost", 32'(bus.ref_lost_o), 32'd1);
    chk("to_valid", 32'(bus.ref_valid_o), 32'd0);
    chk("to_period", 32'(bus.period_o), 32'd52);
    chk("to_clk", 32'(bus.ref_clk_o), 32'd0);
    $display("timeout at cycle %0d after last edge", cyc - last_edge_cyc);

    // Restart: the first edge leaves LOST without touching period_o.
    wave(26, 26);
    chk("rs_lost", 32'(bus.ref_lost_o), 32'd0);
    chk("rs_period", 32'(bus.period_o), 32'd52);
    repeat (4) wave(26, 26);
    chk("rs_valid_pre", 32'(bus.ref_valid_o), 32'd0);
    wave(26, 26);
    chk("rs_valid", 32'(bus.ref_valid_o), 32'd1);

    // Asynchronous reset in the middle of a gated high phase.
    bus.ref_raw_i = 1'b1;
    repeat (15) tick();
    chk("ar_clk_pre", 32'(bus.ref_clk_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_lost", 32'(bus.ref_lost_o), 32'd1);
    chk("ar_valid", 32'(bus.ref_valid_o), 32'd0);
    chk("ar_clk", 32'(bus.ref_clk_o), 32'd0);
    chk("ar_edge", 32'(bus.ref_edge_o), 32'd0);
    chk("ar_period", 32'(bus.period_o), 32'd0);
    bus.ref_raw_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    lock_seq("ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
